// File: rtl/cpu_defs.sv
// Shared CPU definitions: ROM geometry, arbitration owner encoding and
// the byte-address legality rule used by the ROM arbiter.
package cpu_defs;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

  localparam int ROM_ADDR_W = 10;
  localparam int WORD_W     = 32;

  // A byte address is legal when word aligned and inside the ROM window.
  function automatic logic addr_legal(input logic [31:0] addr, input int unsigned aw);
    logic [31:0] hi;
    hi = addr >> (aw + 2);
    return (addr[1:0] == 2'b00) && (hi == 32'd0);
  endfunction

endpackage

// File: rtl/rom_arbiter.sv
// Shares the single-ported instruction ROM between fetch and data-load ports:
// combinational arbitration with starvation guard, one-cycle tagged responses.
module rom_arbiter
  import cpu_defs::*;
#(
  parameter int ADDR_W     = ROM_ADDR_W,
  parameter int DATA_W     = WORD_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_err_o,
  input  logic              mem_req_i,
  input  logic [31:0]       mem_addr_i,
  output logic              mem_gnt_o,
  output logic              mem_rvalid_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_err_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_MEM} resp_t;

  owner_t            owner_p0;
  logic [31:0]       addr_sel_p0;
  logic              legal_p0;
  logic [CNT_W-1:0]  starve_cnt;
  logic [ADDR_W-1:0] addr_hold;
  resp_t             state_p1;
  logic              err_p1;

  // Stage p0: arbitration and address check, same cycle as the request
  always_comb begin
    owner_p0 = OWN_NONE;
    if (rst)
      owner_p0 = OWN_NONE;
    else if (if_req_i && mem_req_i)
      owner_p0 = (starve_cnt == CNT_MAX) ? OWN_IF : OWN_MEM;
    else if (if_req_i)
      owner_p0 = OWN_IF;
    else if (mem_req_i)
      owner_p0 = OWN_MEM;
  end

  assign addr_sel_p0 = (owner_p0 == OWN_IF) ? if_addr_i : mem_addr_i;
  assign legal_p0    = addr_legal(addr_sel_p0, ADDR_W);
  assign if_gnt_o    = (owner_p0 == OWN_IF);
  assign mem_gnt_o   = (owner_p0 == OWN_MEM);
  assign rom_ce_o    = (owner_p0 != OWN_NONE) && legal_p0;
  assign rom_addr_o  = rom_ce_o ? addr_sel_p0[ADDR_W+1:2] : addr_hold;

  // A mem grant with if still requesting can only be a contested win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      addr_hold  <= '0;
    end else begin
      addr_hold <= rom_addr_o;
      if (if_gnt_o || !if_req_i)
        starve_cnt <= '0;
      else if (mem_gnt_o)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Stage p1: response tracker, ROM data arrives this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1 <= IDLE;
      err_p1   <= 1'b0;
    end else begin
      case (owner_p0)
        OWN_IF:  state_p1 <= RESP_IF;
        OWN_MEM: state_p1 <= RESP_MEM;
        default: state_p1 <= IDLE;
      endcase
      err_p1 <= (owner_p0 != OWN_NONE) && !legal_p0;
    end
  end

  assign if_rvalid_o  = (state_p1 == RESP_IF);
  assign if_err_o     = if_rvalid_o && err_p1;
  assign if_rdata_o   = (if_rvalid_o && !err_p1) ? rom_data_i : '0;
  assign mem_rvalid_o = (state_p1 == RESP_MEM);
  assign mem_err_o    = mem_rvalid_o && err_p1;
  assign mem_rdata_o  = (mem_rvalid_o && !err_p1) ? rom_data_i : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed vector table, contention and
// reset sequences, and randomized traffic against a behavioural model.
module tb_rom_arbiter;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = '0;
  logic              if_gnt, if_rvalid, if_err;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_req = 1'b0;
  logic [31:0]       mem_addr = '0;
  logic              mem_gnt, mem_rvalid, mem_err;
  logic [DATA_W-1:0] mem_rdata;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data = '0;

  int passed = 0;
  int total  = 0;

  rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .mem_req_i(mem_req), .mem_addr_i(mem_addr), .mem_gnt_o(mem_gnt),
    .mem_rvalid_o(mem_rvalid), .mem_rdata_o(mem_rdata), .mem_err_o(mem_err),
    .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_data_i(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input int unsigned w);
    return 32'hC0DE_0000 ^ (w * 32'h0001_0003);
  endfunction

  // Behavioural synchronous ROM
  always @(posedge clk) if (rom_ce) rom_data <= rom_word(32'(rom_addr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // rv: 0 none, 1 if port, 2 mem port
  task automatic check_resp(input string tag, input int rv, input logic err, input int word);
    logic [31:0] d;
    d = err ? 32'd0 : rom_word(word);
    check({tag, " if_rvalid"},  32'(if_rvalid),  32'(rv == 1));
    check({tag, " if_err"},     32'(if_err),     32'(rv == 1 && err));
    check({tag, " if_rdata"},   if_rdata,        (rv == 1) ? d : 32'd0);
    check({tag, " mem_rvalid"}, 32'(mem_rvalid), 32'(rv == 2));
    check({tag, " mem_err"},    32'(mem_err),    32'(rv == 2 && err));
    check({tag, " mem_rdata"},  mem_rdata,       (rv == 2) ? d : 32'd0);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic mr, input logic [31:0] ma);
    @(negedge clk);
    if_req = ir; if_addr = ia; mem_req = mr; mem_addr = ma;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic ir; logic [31:0] ia; logic mr; logic [31:0] ma;
    logic eig; logic emg; logic ece; logic [ADDR_W-1:0] era;
    int rv; logic rerr; int word;
  } vec_t;

  function automatic vec_t mk(input int ir, input logic [31:0] ia, input int mr, input logic [31:0] ma,
                              input int eig, input int emg, input int ece, input int era,
                              input int rv, input int rerr, input int word);
    vec_t v;
    v.ir = (ir != 0); v.ia = ia; v.mr = (mr != 0); v.ma = ma;
    v.eig = (eig != 0); v.emg = (emg != 0); v.ece = (ece != 0); v.era = era[ADDR_W-1:0];
    v.rv = rv; v.rerr = (rerr != 0); v.word = word;
    return v;
  endfunction

  // Both ports request every cycle; expected grants follow mem x4, if x1.
  task automatic contention(input string tag, input int n);
    int k = 0;
    int prv = 0;
    int pword = 0;
    logic exp_mem;
    for (int c = 0; c < n; c++) begin
      drive(1'b1, 32'h0, 1'b1, 32'h10 + 32'(4 * k));
      exp_mem = ((c % 5) != 4);
      check({tag, " mem_gnt"}, 32'(mem_gnt), 32'(exp_mem));
      check({tag, " if_gnt"},  32'(if_gnt),  32'(!exp_mem));
      check_resp(tag, prv, 1'b0, pword);
      if (exp_mem) begin prv = 2; pword = 4 + k; k++; end
      else begin prv = 1; pword = 0; end
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check_resp({tag, " tail"}, prv, 1'b0, pword);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 1023) * 4 + $urandom_range(1, 3));
      2:       return 32'h1000 + 32'($urandom_range(0, 4095) * 4);
      default: return 32'($urandom_range(0, 1023) * 4);
    endcase
  endfunction

  vec_t vt[13];

  initial begin
    vt[0]  = mk(1, 32'h8,    0, 32'h0,         1, 0, 1, 2,    0, 0, 0);
    vt[1]  = mk(0, 32'h0,    0, 32'h0,         0, 0, 0, 2,    1, 0, 2);
    vt[2]  = mk(0, 32'h0,    1, 32'h6,         0, 1, 0, 2,    0, 0, 0);
    vt[3]  = mk(1, 32'h1000, 0, 32'h0,         1, 0, 0, 2,    2, 1, 0);
    vt[4]  = mk(1, 32'h0,    0, 32'h0,         1, 0, 1, 0,    1, 1, 0);
    vt[5]  = mk(1, 32'h4,    0, 32'h0,         1, 0, 1, 1,    1, 0, 0);
    vt[6]  = mk(1, 32'h8,    0, 32'h0,         1, 0, 1, 2,    1, 0, 1);
    vt[7]  = mk(1, 32'hC,    0, 32'h0,         1, 0, 1, 3,    1, 0, 2);
    vt[8]  = mk(0, 32'h0,    1, 32'hFFC,       0, 1, 1, 1023, 1, 0, 3);
    vt[9]  = mk(0, 32'h0,    1, 32'h8000_0000, 0, 1, 0, 1023, 2, 0, 1023);
    vt[10] = mk(0, 32'h0,    0, 32'h0,         0, 0, 0, 1023, 2, 1, 0);
    vt[11] = mk(1, 32'h1002, 0, 32'h0,         1, 0, 0, 1023, 0, 0, 0);
    vt[12] = mk(0, 32'h0,    0, 32'h0,         0, 0, 0, 1023, 1, 1, 0);

    // Reset state, with both requests high to show grants are held off
    if_req = 1'b1; mem_req = 1'b1; if_addr = 32'h0; mem_addr = 32'h4;
    repeat (2) @(negedge clk);
    #1;
    check("rst if_gnt",   32'(if_gnt),   32'd0);
    check("rst mem_gnt",  32'(mem_gnt),  32'd0);
    check("rst rom_ce",   32'(rom_ce),   32'd0);
    check("rst rom_addr", 32'(rom_addr), 32'd0);
    check_resp("rst", 0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0;

    for (int i = 0; i < 13; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vt[i].ir, vt[i].ia, vt[i].mr, vt[i].ma);
      check({tag, " if_gnt"},   32'(if_gnt),   32'(vt[i].eig));
      check({tag, " mem_gnt"},  32'(mem_gnt),  32'(vt[i].emg));
      check({tag, " rom_ce"},   32'(rom_ce),   32'(vt[i].ece));
      check({tag, " rom_addr"}, 32'(rom_addr), 32'(vt[i].era));
      check_resp(tag, vt[i].rv, vt[i].rerr, vt[i].word);
    end

    contention("cont", 12);

    // Reset mid-operation: two contested mem wins, then reset in the response cycle
    drive(1'b1, 32'h0, 1'b1, 32'h10);
    check("pre mem_gnt0", 32'(mem_gnt), 32'd1);
    drive(1'b1, 32'h0, 1'b1, 32'h14);
    check("pre mem_gnt1", 32'(mem_gnt), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst if_gnt",   32'(if_gnt),   32'd0);
    check("midrst mem_gnt",  32'(mem_gnt),  32'd0);
    check("midrst rom_ce",   32'(rom_ce),   32'd0);
    check("midrst rom_addr", 32'(rom_addr), 32'd0);
    check_resp("midrst", 0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    #1;
    check_resp("postrst0", 0, 1'b0, 0);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    check_resp("postrst1", 0, 1'b0, 0);
    check("postrst rom_addr", 32'(rom_addr), 32'd0);
    contention("cont2", 10);

    // Randomized traffic against the behavioural model
    do_reset();
    begin
      int s = 0;
      int pv = 0;
      logic perr = 1'b0;
      int pword = 0;
      logic [ADDR_W-1:0] hold = '0;
      logic ir = 1'b0, mr = 1'b0;
      logic [31:0] ia = '0, ma = '0;
      for (int c = 0; c < 500; c++) begin
        logic eig, emg, legal, ece;
        logic [31:0] a;
        logic [ADDR_W-1:0] era;
        if (!ir && $urandom_range(0, 2) != 0) begin ir = 1'b1; ia = rand_addr(); end
        if (!mr && $urandom_range(0, 2) != 0) begin mr = 1'b1; ma = rand_addr(); end
        drive(ir, ia, mr, ma);
        eig   = ir && (!mr || s == STARVE_MAX);
        emg   = mr && !eig;
        a     = eig ? ia : ma;
        legal = ((a % 4) == 0) && (64'(a) < (64'd1 << (ADDR_W + 2)));
        ece   = (eig || emg) && legal;
        era   = ece ? ADDR_W'(a / 4) : hold;
        check("rnd if_gnt",   32'(if_gnt),   32'(eig));
        check("rnd mem_gnt",  32'(mem_gnt),  32'(emg));
        check("rnd rom_ce",   32'(rom_ce),   32'(ece));
        check("rnd rom_addr", 32'(rom_addr), 32'(era));
        check_resp("rnd", pv, perr, pword);
        hold  = era;
        s     = (eig || !ir) ? 0 : (emg ? s + 1 : s);
        pv    = eig ? 1 : (emg ? 2 : 0);
        perr  = !legal;
        pword = int'(a / 4);
        if (eig) ir = 1'b0;
        if (emg) mr = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
